seq_divider: RTL

- Sequential unsigned restoring divider. It is the inverse companion of the team's combinational array multiplier.
- Computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit divisor, one quotient bit per clock.
- Uses a start/busy/done handshake. Sits beside the multiplier in the arithmetic datapath, so products can be checked or undone.

---
 rtl/seq_divider.sv | 118 +++++++++++
 1 files changed

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - sequential unsigned restoring divider, one quotient bit per clock
//
// Ports:
//   clk          rising-edge clock for all state
//   rst          synchronous reset, active-high, overrides every other input
//   start        division request, only looked at while busy=0
//   dividend     numerator, captured on the accepting edge
//   divisor      denominator, captured on the accepting edge
//   busy         high while a division is iterating
//   done         one-cycle pulse in the first cycle the new results are valid
//   quotient     registered quotient, held until the next completion
//   remainder    registered remainder, held until the next completion
//   div_by_zero  high alongside results whose captured divisor was zero

module seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;

  // Working registers. The partial remainder is kept WIDTH bits wide: the
  // restoring step keeps R < D whenever D is non-zero, and with D == 0 it
  // only ever accumulates the dividend, so the extra top bit of the
  // WIDTH+1-bit remainder is always zero once a step has settled.
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] d_reg;

  // One restoring step, computed from the current working registers.
  logic [WIDTH:0]   r_shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;
  logic             last_step;

  always_comb begin
    r_shifted = {r_reg, q_reg[WIDTH-1]};
    trial     = r_shifted - {1'b0, d_reg};
    // Because R < 2D after the shift, the WIDTH+1-bit difference is in
    // range, and its MSB is exactly the borrow that decides the restore.
    if (trial[WIDTH]) begin
      r_next = r_shifted[WIDTH-1:0];
      q_next = {q_reg[WIDTH-2:0], 1'b0};
    end else begin
      r_next = trial[WIDTH-1:0];
      q_next = {q_reg[WIDTH-2:0], 1'b1};
    end
    last_step = (count == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      r_reg       <= '0;
      q_reg       <= '0;
      d_reg       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // Also reached in the done cycle, so a start there is accepted
          // immediately and back-to-back divisions lose no cycle.
          if (start) begin
            q_reg <= dividend;
            d_reg <= divisor;
            r_reg <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          r_reg <= r_next;
          q_reg <= q_next;
          count <= count + CW'(1);
          if (last_step) begin
            quotient    <= q_next;
            remainder   <= r_next;
            div_by_zero <= (d_reg == '0);
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
